// File: rtl/bcd_key_entry.sv
// Keypad digit collector for the BCD-to-binary converter: builds a packed BCD
// operand MSD-first and hands it off with valid/ready. Optional macro: AUTO_ENTER_EN.
module bcd_key_entry #(
   parameter int NDIG = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic [4*NDIG-1:0]            bcd,
   output logic [$clog2(NDIG+1)-1:0]    ndig,
   output logic                         num_valid,
   input  logic                         num_ready,
   output logic                         err,
   output logic                         busy
);

   localparam int NW = $clog2(NDIG+1);
   localparam logic [NW-1:0] FULL = NW'(NDIG);

   typedef enum logic {ENTRY, HOLD} state_t;
   state_t state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ENTRY;
         bcd       <= '0;
         ndig      <= '0;
         num_valid <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ENTRY: begin
               if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     // leading zeros never occupy a digit slot
                     if (ndig != '0 || key_code != 4'd0) begin
                        if (ndig < FULL) begin
                           bcd  <= {bcd[4*NDIG-5:0], key_code};
                           ndig <= ndig + NW'(1);
`ifdef AUTO_ENTER_EN
                           if (ndig == FULL - NW'(1)) begin
                              state     <= HOLD;
                              num_valid <= 1'b1;
                              busy      <= 1'b1;
                           end
`endif
                        end else begin
                           err <= 1'b1;
                        end
                     end
                  end else begin
                     case (key_code)
                        4'hA: begin
                           bcd  <= '0;
                           ndig <= '0;
                        end
                        4'hB: begin
                           if (ndig != '0) begin
                              bcd  <= bcd >> 4;
                              ndig <= ndig - NW'(1);
                           end
                        end
                        4'hC: begin
                           state     <= HOLD;
                           num_valid <= 1'b1;
                           busy      <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            HOLD: begin
               // num_valid is always high here, so ready alone marks the transfer
               if (num_ready) begin
                  state     <= ENTRY;
                  num_valid <= 1'b0;
                  busy      <= 1'b0;
                  bcd       <= '0;
                  ndig      <= '0;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule
